m_logic_serial_ctrl: RTL

- Sequencer that shares one 1-bit logic cell between two 16-bit requesters.
- Arbitrates round-robin, then serialises the selected operation LSB-first over WIDTH cycles, one bit per cycle.
- Assembles the result and returns it over a valid/ready response channel.
- Sits between CPU-side clients (ALU pre-stage, debug port) and the gate-level boolean library.

---
 rtl/m_logic_serial_ctrl_pkg.sv | 17 +
 rtl/m_logic_bit.sv | 31 +++
 rtl/m_logic_gates.sv | 31 +++
 rtl/m_logic_serial_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/m_logic_serial_ctrl_pkg.sv
// rtl/m_logic_serial_ctrl_pkg.sv - shared opcodes, FSM states and width default for the serial logic sequencer
package m_logic_serial_ctrl_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/m_logic_bit.sv
// rtl/m_logic_bit.sv - shared 1-bit logic cell: library gates plus a 4:1 opcode select
module m_logic_bit
    import m_logic_serial_ctrl_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic [1:0] i_op,
    output logic       o_y
);

    logic y_and;
    logic y_or;
    logic y_xor;
    logic y_not;

    m_and u_and (.i_a(i_a), .i_b(i_b), .o_y(y_and));
    m_or  u_or  (.i_a(i_a), .i_b(i_b), .o_y(y_or));
    m_xor u_xor (.i_a(i_a), .i_b(i_b), .o_y(y_xor));
    m_not u_not (.i_a(i_a), .o_y(y_not));

    always_comb begin
        o_y = 1'b0;
        case (i_op)
            OP_AND: o_y = y_and;
            OP_OR:  o_y = y_or;
            OP_XOR: o_y = y_xor;
            OP_NOT: o_y = y_not;
        endcase
    end

endmodule

// File: rtl/m_logic_gates.sv
// rtl/m_logic_gates.sv - primitive 1-bit boolean gates of the gate-level library
module m_and (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module m_or (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a | i_b;
endmodule

module m_xor (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module m_not (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule

// File: rtl/m_logic_serial_ctrl.sv
// rtl/m_logic_serial_ctrl.sv - round-robin sequencer serialising two requesters through one logic cell
module m_logic_serial_ctrl
    import m_logic_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_r0_valid,
    input  logic [1:0]       i_r0_op,
    input  logic [WIDTH-1:0] i_r0_a,
    input  logic [WIDTH-1:0] i_r0_b,
    output logic             o_r0_ready,
    input  logic             i_r1_valid,
    input  logic [1:0]       i_r1_op,
    input  logic [WIDTH-1:0] i_r1_a,
    input  logic [WIDTH-1:0] i_r1_b,
    output logic             o_r1_ready,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_data,
    input  logic             i_rsp_ready,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             grant0;
    logic             grant1;
    logic             cell_y;

    // last_grant_q == 1 means r1 was served last, so r0 wins a tie
    assign grant0 = i_r0_valid & (~i_r1_valid | last_grant_q);
    assign grant1 = i_r1_valid & (~i_r0_valid | ~last_grant_q);

    m_logic_bit u_cell (
        .i_a (a_q[cnt_q]),
        .i_b (b_q[cnt_q]),
        .i_op(op_q),
        .o_y (cell_y)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        o_r0_ready   = 1'b0;
        o_r1_ready   = 1'b0;
        o_rsp_valid  = 1'b0;
        o_rsp_id     = 1'b0;
        o_rsp_data   = '0;
        o_busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // readies are gated by reset so nothing is offered while rst_n is low
                o_r0_ready = grant0 & i_rst_n;
                o_r1_ready = grant1 & i_rst_n;
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    op_d         = grant1 ? i_r1_op : i_r0_op;
                    a_d          = grant1 ? i_r1_a : i_r0_a;
                    b_d          = grant1 ? i_r1_b : i_r0_b;
                    res_d        = '0;
                    cnt_d        = '0;
                    last_grant_d = grant1;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                res_d[cnt_q] = cell_y;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_rsp_valid = 1'b1;
                o_rsp_id    = id_q;
                o_rsp_data  = res_q;
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
